blackjack_deal_ctrl: RTL and testbench

Round sequencer for the blackjack game: fetches cards from the deck source over a request/valid handshake and deals them into player and dealer hand tables. It reacts to hit/stand pulses, runs the dealer draw rule, computes hand scores and the round result. It sits between the deck/input logic and the card-drawing stage, which reads hand slots through a registered lookup port to choose card images.

---
 rtl/blackjack_deal_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_blackjack_deal_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blackjack_deal_ctrl.sv
// blackjack_deal_ctrl: round sequencer for the blackjack game.
// Fetches cards over a req/valid handshake, deals them into the player and
// dealer hand tables, and handles hit/stand. It also runs the dealer draw
// rule, keeps the hand scores and produces the round result.
//
// Parameters: MAX_CARDS  slots per hand (2..15)
// Build macro: DEALER_HITS_SOFT17_EN  when defined, the dealer also draws on a soft 17
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   new_round, hit, stand         one-cycle control pulses
//   card_req / card_valid         deck handshake, transfer when both high
//   card_rank, card_suit          incoming card
//   rd_hand, rd_idx               hand-slot lookup address
//   rd_valid/rank/suit/hidden     registered lookup result (1-cycle latency)
//   player_score, dealer_score    best hand scores, saturated at 31
//   state, result                 FSM state code and round outcome
module blackjack_deal_ctrl #(
  parameter int unsigned MAX_CARDS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_round,
  input  logic       hit,
  input  logic       stand,
  output logic       card_req,
  input  logic       card_valid,
  input  logic [3:0] card_rank,
  input  logic [1:0] card_suit,
  input  logic       rd_hand,
  input  logic [3:0] rd_idx,
  output logic       rd_valid,
  output logic [3:0] rd_rank,
  output logic [1:0] rd_suit,
  output logic       rd_hidden,
  output logic [4:0] player_score,
  output logic [4:0] dealer_score,
  output logic [2:0] state,
  output logic [1:0] result
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned SLOTS = 2 ** IDX_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DEAL   = 3'd1;
  localparam logic [2:0] S_PLAYER = 3'd2;
  localparam logic [2:0] S_DRAW_P = 3'd3;
  localparam logic [2:0] S_DEALER = 3'd4;
  localparam logic [2:0] S_RESULT = 3'd5;

  logic [2:0]       state_q, state_d;
  logic             card_req_q, card_req_d;
  logic [1:0]       result_q, result_d;
  logic             settle_q, settle_d;
  logic [1:0]       deal_cnt_q, deal_cnt_d;
  logic [IDX_W-1:0] p_cnt_q, d_cnt_q;
  logic [5:0]       p_hard_q, d_hard_q;
  logic             p_ace_q, d_ace_q;
  logic [4:0]       p_score_q, d_score_q;
  logic             d_soft_q;
  logic             rd_valid_q, rd_hidden_q;
  logic [3:0]       rd_rank_q;
  logic [1:0]       rd_suit_q;
  logic [3:0]       p_rank_q [SLOTS];
  logic [3:0]       d_rank_q [SLOTS];
  logic [1:0]       p_suit_q [SLOTS];
  logic [1:0]       d_suit_q [SLOTS];

  logic clear_c, xfer_c, xfer_hand_c, draw_c, rd_ok_c;
  logic [1:0] outcome_c;

  // Blackjack value of a rank: ace counts hard as 1, faces as 10.
  function automatic logic [3:0] card_val(input logic [3:0] r);
    return (r >= 4'd10) ? 4'd10 : r;
  endfunction

  // True when an ace can be promoted to 11 without busting.
  function automatic logic is_soft(input logic [5:0] hard, input logic ace);
    return ace && ((7'({1'b0, hard}) + 7'd10) <= 7'd21);
  endfunction

  function automatic logic [4:0] best_score(input logic [5:0] hard, input logic ace);
    logic [6:0] s;
    s = is_soft(hard, ace) ? (7'({1'b0, hard}) + 7'd10) : 7'({1'b0, hard});
    return (s > 7'd31) ? 5'd31 : s[4:0];
  endfunction

  assign xfer_c      = card_req_q && card_valid;
  assign xfer_hand_c = (state_q == S_DEALER) || ((state_q == S_DEAL) && deal_cnt_q[0]);

  // Dealer draw rule, optionally also hitting a soft 17.
`ifdef DEALER_HITS_SOFT17_EN
  assign draw_c = (d_cnt_q < IDX_W'(MAX_CARDS)) &&
                  ((d_score_q < 5'd17) || ((d_score_q == 5'd17) && d_soft_q));
`else
  assign draw_c = (d_cnt_q < IDX_W'(MAX_CARDS)) && (d_score_q < 5'd17);
`endif

  // Round outcome from the settled scores.
  always_comb begin
    outcome_c = 2'd3;
    if (d_score_q > 5'd21)            outcome_c = 2'd1;
    else if (p_score_q > d_score_q)   outcome_c = 2'd1;
    else if (p_score_q < d_score_q)   outcome_c = 2'd2;
  end

  // Next-state logic. Score-based decisions wait one cycle after a transfer
  // (settle_q) so they see the registered score of the new card.
  always_comb begin
    state_d    = state_q;
    card_req_d = card_req_q;
    result_d   = result_q;
    settle_d   = xfer_c;
    deal_cnt_d = deal_cnt_q;
    clear_c    = 1'b0;
    if (xfer_c) card_req_d = 1'b0;
    case (state_q)
      S_IDLE, S_RESULT: begin
        if (new_round) begin
          clear_c    = 1'b1;
          state_d    = S_DEAL;
          card_req_d = 1'b1;
          deal_cnt_d = 2'd0;
          result_d   = 2'd0;
        end
      end
      S_DEAL: begin
        if (xfer_c) begin
          deal_cnt_d = deal_cnt_q + 2'd1;
          if (deal_cnt_q == 2'd3) state_d = S_PLAYER;
          else                    card_req_d = 1'b1;
        end
      end
      S_PLAYER: begin
        if (!settle_q) begin
          if (stand || (p_score_q == 5'd21) || (p_cnt_q >= IDX_W'(MAX_CARDS))) begin
            state_d = S_DEALER;
          end else if (hit && (p_score_q < 5'd21)) begin
            state_d    = S_DRAW_P;
            card_req_d = 1'b1;
          end
        end
      end
      S_DRAW_P: begin
        if (!card_req_q && !settle_q) begin
          if (p_score_q > 5'd21) begin
            state_d  = S_RESULT;
            result_d = 2'd2;
          end else begin
            state_d = S_PLAYER;
          end
        end
      end
      S_DEALER: begin
        if (!card_req_q && !settle_q) begin
          if (draw_c) begin
            card_req_d = 1'b1;
          end else begin
            state_d  = S_RESULT;
            result_d = outcome_c;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        card_req_d = 1'b0;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      card_req_q <= 1'b0;
      result_q   <= 2'd0;
      settle_q   <= 1'b0;
      deal_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      card_req_q <= card_req_d;
      result_q   <= result_d;
      settle_q   <= settle_d;
      deal_cnt_q <= deal_cnt_d;
    end
  end

  // Hand counts, hard sums and ace flags; scores follow one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_cnt_q   <= '0;
      d_cnt_q   <= '0;
      p_hard_q  <= '0;
      d_hard_q  <= '0;
      p_ace_q   <= 1'b0;
      d_ace_q   <= 1'b0;
      p_score_q <= '0;
      d_score_q <= '0;
      d_soft_q  <= 1'b0;
    end else begin
      if (clear_c) begin
        p_cnt_q  <= '0;
        d_cnt_q  <= '0;
        p_hard_q <= '0;
        d_hard_q <= '0;
        p_ace_q  <= 1'b0;
        d_ace_q  <= 1'b0;
      end else if (xfer_c) begin
        if (xfer_hand_c) begin
          d_cnt_q  <= d_cnt_q + IDX_W'(1);
          d_hard_q <= d_hard_q + 6'(card_val(card_rank));
          d_ace_q  <= d_ace_q || (card_rank == 4'd1);
        end else begin
          p_cnt_q  <= p_cnt_q + IDX_W'(1);
          p_hard_q <= p_hard_q + 6'(card_val(card_rank));
          p_ace_q  <= p_ace_q || (card_rank == 4'd1);
        end
      end
      p_score_q <= clear_c ? 5'd0 : best_score(p_hard_q, p_ace_q);
      d_score_q <= clear_c ? 5'd0 : best_score(d_hard_q, d_ace_q);
      d_soft_q  <= clear_c ? 1'b0 : is_soft(d_hard_q, d_ace_q);
    end
  end

  // Slot storage; occupancy comes from the counts, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (xfer_c) begin
      if (xfer_hand_c) begin
        d_rank_q[d_cnt_q] <= card_rank;
        d_suit_q[d_cnt_q] <= card_suit;
      end else begin
        p_rank_q[p_cnt_q] <= card_rank;
        p_suit_q[p_cnt_q] <= card_suit;
      end
    end
  end

  assign rd_ok_c = (rd_idx < IDX_W'(MAX_CARDS)) && (rd_idx < (rd_hand ? d_cnt_q : p_cnt_q));

  // Registered lookup port for the card drawer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q  <= 1'b0;
      rd_rank_q   <= '0;
      rd_suit_q   <= '0;
      rd_hidden_q <= 1'b0;
    end else begin
      rd_valid_q  <= rd_ok_c;
      rd_rank_q   <= rd_ok_c ? (rd_hand ? d_rank_q[rd_idx] : p_rank_q[rd_idx]) : 4'd0;
      rd_suit_q   <= rd_ok_c ? (rd_hand ? d_suit_q[rd_idx] : p_suit_q[rd_idx]) : 2'd0;
      rd_hidden_q <= rd_hand && (rd_idx == 4'd1) &&
                     ((state_q == S_DEAL) || (state_q == S_PLAYER) || (state_q == S_DRAW_P));
    end
  end

  assign card_req     = card_req_q;
  assign state        = state_q;
  assign result       = result_q;
  assign player_score = p_score_q;
  assign dealer_score = d_score_q;
  assign rd_valid     = rd_valid_q;
  assign rd_rank      = rd_rank_q;
  assign rd_suit      = rd_suit_q;
  assign rd_hidden    = rd_hidden_q;

endmodule

// File: tb/tb_blackjack_deal_ctrl.sv
// Testbench for blackjack_deal_ctrl: directed rounds with a deck scoreboard
// (each card carries the FSM state expected at its transfer) plus a second
// instance with MAX_CARDS=3 for the full-hand case.
module tb_blackjack_deal_ctrl;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DEAL   = 3'd1;
  localparam logic [2:0] S_PLAYER = 3'd2;
  localparam logic [2:0] S_DRAW_P = 3'd3;
  localparam logic [2:0] S_DEALER = 3'd4;
  localparam logic [2:0] S_RESULT = 3'd5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, new_round, hit, stand, card_valid, rd_hand;
  logic [3:0] card_rank, rd_idx;
  logic [1:0] card_suit;
  logic       card_req, rd_valid, rd_hidden;
  logic [3:0] rd_rank;
  logic [1:0] rd_suit, result;
  logic [4:0] player_score, dealer_score;
  logic [2:0] state;

  logic       new_round_b, card_valid_b;
  logic [3:0] card_rank_b;
  logic [1:0] card_suit_b;
  logic       card_req_b, rd_valid_b, rd_hidden_b;
  logic [3:0] rd_rank_b;
  logic [1:0] rd_suit_b, result_b;
  logic [4:0] player_score_b, dealer_score_b;
  logic [2:0] state_b;

  blackjack_deal_ctrl #(.MAX_CARDS(8)) dut (
    .clk(clk), .rst(rst), .new_round(new_round), .hit(hit), .stand(stand),
    .card_req(card_req), .card_valid(card_valid), .card_rank(card_rank), .card_suit(card_suit),
    .rd_hand(rd_hand), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_rank(rd_rank),
    .rd_suit(rd_suit), .rd_hidden(rd_hidden), .player_score(player_score),
    .dealer_score(dealer_score), .state(state), .result(result)
  );

  blackjack_deal_ctrl #(.MAX_CARDS(3)) dut_b (
    .clk(clk), .rst(rst), .new_round(new_round_b), .hit(hit), .stand(stand),
    .card_req(card_req_b), .card_valid(card_valid_b), .card_rank(card_rank_b), .card_suit(card_suit_b),
    .rd_hand(rd_hand), .rd_idx(rd_idx), .rd_valid(rd_valid_b), .rd_rank(rd_rank_b),
    .rd_suit(rd_suit_b), .rd_hidden(rd_hidden_b), .player_score(player_score_b),
    .dealer_score(dealer_score_b), .state(state_b), .result(result_b)
  );

  typedef struct {
    logic [3:0] rank;
    logic [1:0] suit;
    logic [2:0] st;
  } card_t;

  typedef struct {
    logic       v;
    logic [3:0] r;
    logic [1:0] s;
    logic       h;
  } rd_exp_t;

  card_t   deck[$];
  rd_exp_t rd_exp[$];
  logic    spurious = 1'b0;
  int      vectors = 0;
  int      errors  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Deck model: presents the head card while the DUT requests one.
  always @(negedge clk) begin
    if (card_req && deck.size() != 0) begin
      card_valid = 1'b1;
      card_rank  = deck[0].rank;
      card_suit  = deck[0].suit;
    end else if (spurious) begin
      card_valid = 1'b1;
      card_rank  = 4'd13;
      card_suit  = 2'd0;
    end else begin
      card_valid = 1'b0;
    end
  end

  // Transfer monitor: every accepted card must be one we queued, in the expected state.
  always @(posedge clk) begin
    if (!rst && card_req && card_valid) begin
      vectors++;
      assert (deck.size() != 0) else begin
        errors++;
        $error("FAIL xfer_extra: observed transfer in state %0d expected none", state);
      end
      if (deck.size() != 0) begin
        check("xfer_state", 32'(state), 32'(deck[0].st));
        void'(deck.pop_front());
      end
    end
  end

  task automatic push_card(input logic [3:0] r, input logic [1:0] s, input logic [2:0] st);
    card_t c;
    c.rank = r; c.suit = s; c.st = st;
    deck.push_back(c);
  endtask

  // 0=new_round, 1=hit, 2=stand, 3=hit+stand, 4=new_round_b
  task automatic pulse(input int which);
    @(negedge clk);
    new_round   = (which == 0);
    hit         = (which == 1) || (which == 3);
    stand       = (which == 2) || (which == 3);
    new_round_b = (which == 4);
    @(negedge clk);
    new_round = 1'b0; hit = 1'b0; stand = 1'b0; new_round_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input logic use_b, input string tag);
    int n = 0;
    while (((use_b ? state_b : state) !== s) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check(tag, 32'(use_b ? state_b : state), 32'(s));
  endtask

  task automatic rd_check(input string tag, input logic h, input logic [3:0] i, input logic use_b,
                          input logic ev, input logic [3:0] er, input logic [1:0] es, input logic eh);
    rd_exp_t e, g;
    @(negedge clk);
    rd_hand = h; rd_idx = i;
    e.v = ev; e.r = er; e.s = es; e.h = eh;
    rd_exp.push_back(e);
    @(posedge clk); @(posedge clk); #1;
    g = rd_exp.pop_front();
    check({tag, ".valid"},  32'(use_b ? rd_valid_b  : rd_valid),  32'(g.v));
    check({tag, ".rank"},   32'(use_b ? rd_rank_b   : rd_rank),   32'(g.r));
    check({tag, ".suit"},   32'(use_b ? rd_suit_b   : rd_suit),   32'(g.s));
    check({tag, ".hidden"}, 32'(use_b ? rd_hidden_b : rd_hidden), 32'(g.h));
  endtask

  task automatic give_card_b(input logic [3:0] r, input logic [1:0] s);
    int n = 0;
    while (card_req_b !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("b_card_req", 32'(card_req_b), 32'd1);
    @(negedge clk);
    card_valid_b = 1'b1; card_rank_b = r; card_suit_b = s;
    @(negedge clk);
    card_valid_b = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; new_round = 1'b0; hit = 1'b0; stand = 1'b0;
    card_valid = 1'b0; card_rank = 4'd0; card_suit = 2'd0;
    rd_hand = 1'b0; rd_idx = 4'd0;
    new_round_b = 1'b0; card_valid_b = 1'b0; card_rank_b = 4'd0; card_suit_b = 2'd0;
    idle(3);
    check("rst_state", 32'(state), 32'(S_IDLE));
    check("rst_req", 32'(card_req), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_pscore", 32'(player_score), 32'd0);
    check("rst_dscore", 32'(dealer_score), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_rank", 32'(rd_rank), 32'd0);
    check("rst_rd_hidden", 32'(rd_hidden), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Deal: 10S, 9H, 5D, 7C back-to-back.
    push_card(4'd10, 2'd0, S_DEAL); push_card(4'd9, 2'd1, S_DEAL);
    push_card(4'd5, 2'd2, S_DEAL);  push_card(4'd7, 2'd3, S_DEAL);
    pulse(0);
    wait_state(S_PLAYER, 1'b0, "deal_state");
    idle(3);
    check("deal_pscore", 32'(player_score), 32'd15);
    check("deal_dscore", 32'(dealer_score), 32'd16);
    check("deal_deck_used", 32'(deck.size()), 32'd0);
    rd_check("deal_p0", 1'b0, 4'd0, 1'b0, 1'b1, 4'd10, 2'd0, 1'b0);
    rd_check("deal_p1", 1'b0, 4'd1, 1'b0, 1'b1, 4'd5, 2'd2, 1'b0);
    rd_check("deal_d0", 1'b1, 4'd0, 1'b0, 1'b1, 4'd9, 2'd1, 1'b0);
    rd_check("deal_d1", 1'b1, 4'd1, 1'b0, 1'b1, 4'd7, 2'd3, 1'b1);
    rd_check("deal_p2", 1'b0, 4'd2, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0);
    rd_check("oor_idx", 1'b0, 4'd12, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0);

    // Valid without request must not write a slot.
    @(negedge clk); spurious = 1'b1;
    idle(4);
    @(negedge clk); spurious = 1'b0;
    rd_check("spur_p2", 1'b0, 4'd2, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0);
    check("spur_state", 32'(state), 32'(S_PLAYER));

    // Player bust on K.
    push_card(4'd13, 2'd0, S_DRAW_P);
    pulse(1);
    wait_state(S_RESULT, 1'b0, "bust_state");
    check("bust_pscore", 32'(player_score), 32'd25);
    check("bust_result", 32'(result), 32'd2);
    idle(5);
    check("bust_no_req", 32'(card_req), 32'd0);
    check("bust_dscore", 32'(dealer_score), 32'd16);

    // Dealer draw loop: player 10,8; dealer 9,7 draws a 4.
    push_card(4'd10, 2'd0, S_DEAL); push_card(4'd9, 2'd1, S_DEAL);
    push_card(4'd8, 2'd2, S_DEAL);  push_card(4'd7, 2'd3, S_DEAL);
    push_card(4'd4, 2'd0, S_DEALER);
    pulse(0);
    check("clear_result", 32'(result), 32'd0);
    wait_state(S_PLAYER, 1'b0, "loop_player");
    idle(3);
    pulse(2);
    wait_state(S_RESULT, 1'b0, "loop_state");
    check("loop_dscore", 32'(dealer_score), 32'd20);
    check("loop_pscore", 32'(player_score), 32'd18);
    check("loop_result", 32'(result), 32'd2);
    idle(5);
    check("loop_deck_used", 32'(deck.size()), 32'd0);
    rd_check("loop_d2", 1'b1, 4'd2, 1'b0, 1'b1, 4'd4, 2'd0, 1'b0);
    rd_check("loop_d3", 1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0);

    // Soft 17: player 10,9; dealer A,6.
    push_card(4'd10, 2'd0, S_DEAL); push_card(4'd1, 2'd1, S_DEAL);
    push_card(4'd9, 2'd2, S_DEAL);  push_card(4'd6, 2'd3, S_DEAL);
`ifdef DEALER_HITS_SOFT17_EN
    push_card(4'd2, 2'd0, S_DEALER);
`endif
    pulse(0);
    wait_state(S_PLAYER, 1'b0, "s17_player");
    idle(3);
    check("s17_dscore_hole", 32'(dealer_score), 32'd17);
    pulse(2);
    wait_state(S_RESULT, 1'b0, "s17_state");
`ifdef DEALER_HITS_SOFT17_EN
    check("s17_dscore", 32'(dealer_score), 32'd19);
    check("s17_result", 32'(result), 32'd3);
`else
    check("s17_dscore", 32'(dealer_score), 32'd17);
    check("s17_result", 32'(result), 32'd1);
`endif
    idle(5);
    check("s17_deck_used", 32'(deck.size()), 32'd0);
    rd_check("s17_d1_shown", 1'b1, 4'd1, 1'b0, 1'b1, 4'd6, 2'd3, 1'b0);

    // Hit and stand together: stand wins, dealer 9,7 draws a 5.
    push_card(4'd10, 2'd0, S_DEAL); push_card(4'd9, 2'd1, S_DEAL);
    push_card(4'd6, 2'd2, S_DEAL);  push_card(4'd7, 2'd3, S_DEAL);
    push_card(4'd5, 2'd1, S_DEALER);
    pulse(0);
    wait_state(S_PLAYER, 1'b0, "hs_player");
    idle(3);
    pulse(3);
    wait_state(S_RESULT, 1'b0, "hs_state");
    check("hs_pscore", 32'(player_score), 32'd16);
    check("hs_dscore", 32'(dealer_score), 32'd21);
    check("hs_result", 32'(result), 32'd2);
    rd_check("hs_p2", 1'b0, 4'd2, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0);

    // Reset while the dealer is requesting a card.
    push_card(4'd10, 2'd0, S_DEAL); push_card(4'd9, 2'd1, S_DEAL);
    push_card(4'd8, 2'd2, S_DEAL);  push_card(4'd7, 2'd3, S_DEAL);
    pulse(0);
    wait_state(S_PLAYER, 1'b0, "rst_mid_player");
    idle(3);
    pulse(2);
    wait_state(S_DEALER, 1'b0, "rst_mid_dealer");
    idle(3);
    check("rst_mid_req_before", 32'(card_req), 32'd1);
    @(negedge clk); rst = 1'b1;
    #1;
    check("rst_mid_state", 32'(state), 32'(S_IDLE));
    check("rst_mid_req", 32'(card_req), 32'd0);
    check("rst_mid_pscore", 32'(player_score), 32'd0);
    check("rst_mid_dscore", 32'(dealer_score), 32'd0);
    idle(2);
    @(negedge clk); rst = 1'b0;
    rd_check("rst_mid_d0", 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0);
    rd_check("rst_mid_p0", 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0);

    // Full hand with MAX_CARDS=3: player A,2 then 3 => soft 16, auto advance.
    pulse(4);
    give_card_b(4'd1, 2'd0); give_card_b(4'd10, 2'd1);
    give_card_b(4'd2, 2'd2); give_card_b(4'd7, 2'd3);
    wait_state(S_PLAYER, 1'b1, "b_player");
    idle(3);
    check("b_pscore_deal", 32'(player_score_b), 32'd13);
    pulse(1);
    give_card_b(4'd3, 2'd0);
    wait_state(S_RESULT, 1'b1, "b_state");
    check("b_pscore", 32'(player_score_b), 32'd16);
    check("b_dscore", 32'(dealer_score_b), 32'd17);
    check("b_result", 32'(result_b), 32'd2);
    rd_check("b_p2", 1'b0, 4'd2, 1'b1, 1'b1, 4'd3, 2'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
